// File: rtl/golden_nonce_reporter.sv
// Golden nonce reporter: detects rising per-core hit flags, queues the nonces and sends each one as a byte frame.
// Define NONCE_REPORT_CORE_ID_EN to append a core-id byte to every frame.
module golden_nonce_reporter #(
    parameter int          NUM_CORES = 2,
    parameter int          DEPTH     = 4,
    parameter logic [7:0]  HEADER    = 8'hA5
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [NUM_CORES-1:0]   flag,
    input  logic [31:0]            golden_nonce,
    input  logic                   clear,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef NONCE_REPORT_CORE_ID_EN
    localparam int EW = 40;
`else
    localparam int EW = 32;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_B3, S_B2, S_B1, S_B0
`ifdef NONCE_REPORT_CORE_ID_EN
        , S_ID
`endif
    } state_t;

    state_t               state, state_nxt;
    logic [NUM_CORES-1:0] flag_q, rise;
    logic                 pend;
    logic [EW-1:0]        mem [DEPTH];
    logic [EW-1:0]        entry, frame;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 full, last_byte, pop, push_ok;

    assign rise = flag & ~flag_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            flag_q <= '0;
            pend   <= 1'b0;
        end else begin
            flag_q <= flag;
            pend   <= (|rise) & ~clear;
        end
    end

`ifdef NONCE_REPORT_CORE_ID_EN
    logic [7:0] rise_id, id_q;

    // Lowest-numbered core wins when several flags rise together.
    always_comb begin
        rise_id = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (rise[i]) rise_id = 8'(i);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)      id_q <= '0;
        else if (|rise)  id_q <= rise_id;
    end

    assign entry     = {id_q, golden_nonce};
    assign last_byte = (state == S_ID);
`else
    assign entry     = golden_nonce;
    assign last_byte = (state == S_B0);
`endif

    // Pop either from idle or straight after the final byte of a frame is taken.
    assign full    = (count == CW'(DEPTH));
    assign pop     = (count != '0) & ~clear & ((state == S_IDLE) | (last_byte & tx_ready));
    assign push_ok = pend & ~clear & (~full | pop);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop);
            if (pend & full & ~pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)   frame <= '0;
        else if (pop) frame <= mem[rd_ptr];
    end

    assign fifo_count = count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (pop)      state_nxt = S_HDR;
            S_HDR:  if (tx_ready) state_nxt = S_B3;
            S_B3:   if (tx_ready) state_nxt = S_B2;
            S_B2:   if (tx_ready) state_nxt = S_B1;
            S_B1:   if (tx_ready) state_nxt = S_B0;
`ifdef NONCE_REPORT_CORE_ID_EN
            S_B0:   if (tx_ready) state_nxt = S_ID;
            S_ID:   if (tx_ready) state_nxt = pop ? S_HDR : S_IDLE;
`else
            S_B0:   if (tx_ready) state_nxt = pop ? S_HDR : S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx_valid = (state != S_IDLE);
        tx_data  = 8'h00;
        case (state)
            S_HDR: tx_data = HEADER;
            S_B3:  tx_data = frame[31:24];
            S_B2:  tx_data = frame[23:16];
            S_B1:  tx_data = frame[15:8];
            S_B0:  tx_data = frame[7:0];
`ifdef NONCE_REPORT_CORE_ID_EN
            S_ID:  tx_data = frame[39:32];
`endif
            default: tx_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Bench for golden_nonce_reporter: directed scenarios plus random traffic against a queue-based reference model.
module tb_golden_nonce_reporter;
    localparam int         NC    = 2;
    localparam int         DEPTH = 4;
    localparam logic [7:0] HDR   = 8'hA5;
`ifdef NONCE_REPORT_CORE_ID_EN
    localparam int FB = 6;
`else
    localparam int FB = 5;
`endif

    logic                   clk = 1'b0;
    logic                   n_rst, clear, tx_ready, tx_valid, overflow;
    logic [NC-1:0]          flag;
    logic [31:0]            golden_nonce;
    logic [7:0]             tx_data;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    golden_nonce_reporter #(.NUM_CORES(NC), .DEPTH(DEPTH), .HEADER(HDR)) dut (
        .clk(clk), .n_rst(n_rst), .flag(flag), .golden_nonce(golden_nonce), .clear(clear),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] nonce; logic [7:0] id; } hit_t;
    hit_t       hq[$];
    logic [7:0] cur[$];
    logic [7:0] exp_log[$];
    logic [7:0] rx[$];
    logic [NC-1:0] m_prev;
    bit         m_pend, m_ovf;
    logic [7:0] m_pid;
    logic [7:0] single_exp [6] = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rxb(input int i);
        return (i < rx.size()) ? {24'h0, rx[i]} : 32'hxxxxxxxx;
    endfunction

    function automatic int lowest(input logic [NC-1:0] v);
        for (int i = 0; i < NC; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        hq.delete(); cur.delete();
        m_prev = '0; m_pend = 0; m_pid = '0; m_ovf = 0;
    endtask

    // Advances the model by one clock using the inputs that were present at that edge.
    task automatic model_step();
        bit acc, done, start;
        hit_t h;
        logic [NC-1:0] r;
        acc   = (cur.size() > 0) && tx_ready;
        done  = acc && (cur.size() == 1);
        start = (cur.size() == 0 || done) && (hq.size() > 0) && !clear;
        if (acc) void'(cur.pop_front());
        if (clear) begin
            hq.delete(); m_ovf = 0; m_pend = 0;
        end else begin
            if (start) begin
                h = hq.pop_front();
                cur.push_back(HDR);
                for (int k = 3; k >= 0; k--) cur.push_back(h.nonce[8*k +: 8]);
                if (FB == 6) cur.push_back(h.id);
                foreach (cur[k]) exp_log.push_back(cur[k]);
            end
            if (m_pend) begin
                if (hq.size() < DEPTH) begin
                    h.nonce = golden_nonce; h.id = m_pid;
                    hq.push_back(h);
                end else m_ovf = 1;
            end
            r = flag & ~m_prev;
            m_pend = |r;
            if (|r) m_pid = 8'(lowest(r));
        end
        m_prev = flag;
    endtask

    task automatic chk_out();
        chk("tx_valid",   32'(tx_valid),   32'(cur.size() > 0));
        chk("tx_data",    32'(tx_data),    32'((cur.size() > 0) ? cur[0] : 8'h00));
        chk("fifo_count", 32'(fifo_count), 32'(hq.size()));
        chk("overflow",   32'(overflow),   32'(m_ovf));
    endtask

    task automatic cycle();
        bit hs;
        logic [7:0] b;
        hs = tx_valid && tx_ready;
        b  = tx_data;
        @(posedge clk); #1;
        if (hs) rx.push_back(b);
        model_step();
        chk_out();
    endtask

    task automatic hit(input logic [NC-1:0] f);
        flag = f; golden_nonce = $urandom; cycle();
        flag = '0; golden_nonce = $urandom; cycle();
    endtask

    initial begin
        bit found;
        n_rst = 1'b0; flag = '0; golden_nonce = '0; clear = 1'b0; tx_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_data",  32'(tx_data), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        @(negedge clk) n_rst = 1'b1;
        repeat (2) cycle();

        // single hit, nonce follows the flag by one cycle
        rx.delete(); tx_ready = 1'b1;
        flag = 2'b01; golden_nonce = $urandom; cycle();
        golden_nonce = 32'hDEADBEEF; cycle();
        golden_nonce = $urandom; repeat (10) cycle();
        chk("single_len", 32'(rx.size()), 32'(FB));
        for (int i = 0; i < FB; i++) chk("single_byte", rxb(i), 32'(single_exp[i]));
        flag = '0; repeat (2) cycle();

        // backpressure while B2 is on the link
        rx.delete();
        flag = 2'b01; golden_nonce = $urandom; cycle();
        golden_nonce = 32'hDEADBEEF; cycle();
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (cur.size() == FB - 2) found = 1;
            else cycle();
        end
        chk("reach_b2", 32'(found), 32'd1);
        tx_ready = 1'b0;
        repeat (3) begin
            cycle();
            chk("bp_data",  32'(tx_data), 32'h0000_00AD);
            chk("bp_valid", 32'(tx_valid), 32'd1);
        end
        tx_ready = 1'b1; repeat (10) cycle();
        chk("bp_len", 32'(rx.size()), 32'(FB));
        for (int i = 0; i < FB; i++) chk("bp_byte", rxb(i), 32'(single_exp[i]));
        flag = '0; cycle();

        // overflow: first hit goes in flight, four queue, the sixth is dropped
        rx.delete(); exp_log.delete(); tx_ready = 1'b0;
        repeat (6) hit(2'b01);
        cycle();
        chk("ovf_count", 32'(fifo_count), 32'd4);
        chk("ovf_flag",  32'(overflow), 32'd1);
        tx_ready = 1'b1; repeat (5 * FB + 6) cycle();
        chk("ovf_drain_len", 32'(rx.size()), 32'(5 * FB));
        chk("ovf_log_len", 32'(exp_log.size()), 32'(5 * FB));
        for (int i = 0; i < 5 * FB; i++)
            if (i < exp_log.size()) chk("ovf_order", rxb(i), 32'(exp_log[i]));
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // held flag yields one frame
        rx.delete(); flag = 2'b10; repeat (20) cycle();
        chk("held_len", 32'(rx.size()), 32'(FB));
        chk("held_hdr", rxb(0), 32'(HDR));
`ifdef NONCE_REPORT_CORE_ID_EN
        chk("held_id", rxb(FB - 1), 32'h01);
`endif
        flag = '0; cycle();

        // clear during B3 with two hits queued
        rx.delete(); tx_ready = 1'b0;
        repeat (3) hit(2'b01);
        cycle();
        chk("clr_pre_count", 32'(fifo_count), 32'd2);
        tx_ready = 1'b1; cycle();
        tx_ready = 1'b0; clear = 1'b1; cycle();
        clear = 1'b0;
        chk("clr_count", 32'(fifo_count), 32'd0);
        chk("clr_ovf",   32'(overflow), 32'd0);
        chk("clr_inflight", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1; repeat (25) cycle();
        chk("clr_len", 32'(rx.size()), 32'(FB));
        chk("clr_hdr", rxb(0), 32'(HDR));

        // async reset while B1 is on the link
        rx.delete(); tx_ready = 1'b1;
        hit(2'b10);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (cur.size() == FB - 3) found = 1;
            else cycle();
        end
        chk("reach_b1", 32'(found), 32'd1);
        tx_ready = 1'b0;
        #3 n_rst = 1'b0;
        #1;
        chk("arst_valid", 32'(tx_valid), 32'd0);
        chk("arst_data",  32'(tx_data), 32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        model_reset();
        @(negedge clk) n_rst = 1'b1; flag = '0;
        rx.delete(); tx_ready = 1'b1;
        flag = 2'b01; golden_nonce = $urandom; cycle();
        golden_nonce = $urandom; repeat (12) cycle();
        chk("arst_len", 32'(rx.size()), 32'(FB));
        chk("arst_hdr", rxb(0), 32'(HDR));
        flag = '0; cycle();

        // random traffic
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) flag = NC'($urandom);
            golden_nonce = $urandom;
            tx_ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 39) == 0);
            cycle();
        end
        clear = 1'b0; tx_ready = 1'b1; flag = '0;
        repeat (60) cycle();
        chk("final_idle", 32'(tx_valid), 32'd0);
        chk("final_count", 32'(fifo_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
